// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: FSM state encodings and default bit timing.
// Used by both the receiver and the transmitter.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      START     = 3'd1,
      DATA_BITS = 3'd2,
      STOP      = 3'd3,
      CLEAN     = 3'd4
   } uart_state_e;

   localparam int CLKS_PER_BIT_DEF = 4;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for asynchronous inputs.
// Both stages reset to 1 so an idle-high line never looks like a start bit.
module uart_rx_sync #(
   parameter int WIDTH = 1
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic [WIDTH-1:0] i_d,
   output logic [WIDTH-1:0] o_q
);

   logic [WIDTH-1:0] meta_q;
   logic [WIDTH-1:0] sync_q;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         meta_q <= '1;
         sync_q <= '1;
      end else begin
         meta_q <= i_d;
         sync_q <= meta_q;
      end
   end

   assign o_q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronise, confirm start at mid-bit, sample
// data mid-bit, check stop bit, strobe the received byte.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int m            = 8
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_enable,
   input  logic         i_Rx_serial,
   output logic         o_Rx_DV,
   output logic [m-1:0] o_Rx_byte,
   output logic         o_Rx_active,
   output logic         o_frame_err
);

   localparam int CW = $clog2(CLKS_PER_BIT) + 1;
   localparam int BW = (m > 1) ? $clog2(m) : 1;
   localparam logic [CW-1:0] HALF_C   = CW'((CLKS_PER_BIT - 1) / 2);
   localparam logic [CW-1:0] LAST_C   = CW'(CLKS_PER_BIT - 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(m - 1);

   logic rx_s;

   uart_state_e    state_q, state_d;
   logic [CW-1:0]  count_q, count_d;
   logic [BW-1:0]  bit_q, bit_d;
   logic [m-1:0]   shift_q, shift_d;
   logic [m-1:0]   byte_q, byte_d;
   logic           dv_q, dv_d;
   logic           ferr_q, ferr_d;
   logic           active_q, active_d;

   uart_rx_sync #(.WIDTH(1)) u_sync (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_d     (i_Rx_serial),
      .o_q     (rx_s)
   );

   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      bit_d    = bit_q;
      shift_d  = shift_q;
      byte_d   = byte_q;
      dv_d     = 1'b0;
      ferr_d   = 1'b0;
      active_d = active_q;
      unique case (state_q)
         IDLE: begin
            count_d  = '0;
            bit_d    = '0;
            active_d = 1'b0;
            if (i_enable && !rx_s) state_d = START;
         end
         START: begin
            if (!i_enable) begin
               state_d  = IDLE;
               count_d  = '0;
               active_d = 1'b0;
            end else if (count_q == HALF_C) begin
               count_d = '0;
               if (!rx_s) begin
                  state_d  = DATA_BITS;
                  bit_d    = '0;
                  active_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         DATA_BITS: begin
            if (!i_enable) begin
               state_d  = IDLE;
               count_d  = '0;
               active_d = 1'b0;
            end else if (count_q == LAST_C) begin
               count_d        = '0;
               shift_d[bit_q] = rx_s;
               if (bit_q == LAST_BIT) state_d = STOP;
               else bit_d = bit_q + 1'b1;
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         STOP: begin
            if (!i_enable) begin
               state_d  = IDLE;
               count_d  = '0;
               active_d = 1'b0;
            end else if (count_q == LAST_C) begin
               count_d  = '0;
               active_d = 1'b0;
               state_d  = CLEAN;
               if (rx_s) begin
                  byte_d = shift_q;
                  dv_d   = 1'b1;
               end else begin
                  ferr_d = 1'b1;
               end
            end else begin
               count_d = count_q + 1'b1;
            end
         end
         CLEAN: begin
            count_d = '0;
            bit_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d  = IDLE;
            count_d  = '0;
            bit_d    = '0;
            active_d = 1'b0;
         end
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= IDLE;
         count_q  <= '0;
         bit_q    <= '0;
         shift_q  <= '0;
         byte_q   <= '0;
         dv_q     <= 1'b0;
         ferr_q   <= 1'b0;
         active_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         count_q  <= count_d;
         bit_q    <= bit_d;
         shift_q  <= shift_d;
         byte_q   <= byte_d;
         dv_q     <= dv_d;
         ferr_q   <= ferr_d;
         active_q <= active_d;
      end
   end

   assign o_Rx_DV     = dv_q;
   assign o_Rx_byte   = byte_q;
   assign o_Rx_active = active_q;
   assign o_frame_err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 4 clocks/bit plus a serial loopback at 8.
// A behavioural transmitter drives the 8-clock receiver.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       en4, rx4, dv4, act4, ferr4;
   logic [7:0] byte4;
   logic       en8, rx8, dv8, act8, ferr8;
   logic [7:0] byte8;

   int checks = 0;
   int errors = 0;

   int dv4_cnt = 0, ferr4_cnt = 0, act4_cnt = 0, b2b4 = 0;
   int ferr8_cnt = 0;
   logic dv4_prev = 1'b0;
   logic [7:0] got4[$];
   logic [7:0] got8[$];
   logic [7:0] exp8[$];

   always #5 clk = ~clk;

   uart_rx #(.CLKS_PER_BIT(4), .m(8)) dut4 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (en4),
      .i_Rx_serial (rx4),
      .o_Rx_DV     (dv4),
      .o_Rx_byte   (byte4),
      .o_Rx_active (act4),
      .o_frame_err (ferr4)
   );

   uart_rx #(.CLKS_PER_BIT(8), .m(8)) dut8 (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (en8),
      .i_Rx_serial (rx8),
      .o_Rx_DV     (dv8),
      .o_Rx_byte   (byte8),
      .o_Rx_active (act8),
      .o_frame_err (ferr8)
   );

   always @(negedge clk) begin
      if (dv4) begin
         dv4_cnt++;
         got4.push_back(byte4);
         if (dv4_prev) b2b4++;
      end
      dv4_prev = dv4;
      if (ferr4) ferr4_cnt++;
      if (act4) act4_cnt++;
      if (dv8) got8.push_back(byte8);
      if (ferr8) ferr8_cnt++;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // drop_at: data bit index at which enable is pulled low (-1 = never)
   task automatic frame4(input logic [7:0] b, input logic stopb,
                         input int drop_at);
      rx4 = 1'b0;
      idle(4);
      for (int i = 0; i < 8; i++) begin
         if (i == drop_at) en4 = 1'b0;
         rx4 = b[i];
         idle(4);
      end
      rx4 = stopb;
      idle(4);
      rx4 = 1'b1;
   endtask

   // rst_at: data bit index at which reset is pulsed and the frame dropped
   task automatic frame8(input logic [7:0] b, input int rst_at);
      rx8 = 1'b0;
      idle(8);
      for (int i = 0; i < 8; i++) begin
         if (i == rst_at) begin
            rst_n = 1'b0;
            rx8   = 1'b1;
            idle(3);
            rst_n = 1'b1;
            return;
         end
         rx8 = b[i];
         idle(8);
      end
      rx8 = 1'b1;
      idle(8);
   endtask

   initial begin
      int a0;
      int n;
      logic [7:0] b;
      rst_n = 1'b0;
      en4 = 1'b1;
      rx4 = 1'b1;
      en8 = 1'b1;
      rx8 = 1'b1;
      idle(3);
      chk("rst_dv", dv4, 1'b0);
      chk("rst_byte", byte4, 8'h00);
      chk("rst_active", act4, 1'b0);
      chk("rst_ferr", ferr4, 1'b0);
      rst_n = 1'b1;
      idle(10);

      a0 = act4_cnt;
      frame4(8'hA5, 1'b1, -1);
      idle(16);
      chk("a5_dv_cnt", dv4_cnt, 1);
      chk("a5_got", got4[0], 8'hA5);
      chk("a5_byte", byte4, 8'hA5);
      chk("a5_ferr", ferr4_cnt, 0);
      chk("a5_active_cycles", act4_cnt - a0, 36);
      chk("a5_active_end", act4, 1'b0);

      a0 = act4_cnt;
      rx4 = 1'b0;
      idle(1);
      rx4 = 1'b1;
      idle(16);
      chk("glitch_dv", dv4_cnt, 1);
      chk("glitch_ferr", ferr4_cnt, 0);
      chk("glitch_active", act4_cnt - a0, 0);

      frame4(8'h3C, 1'b0, -1);
      idle(16);
      chk("ferr_cnt", ferr4_cnt, 1);
      chk("ferr_dv", dv4_cnt, 1);
      chk("ferr_byte_kept", byte4, 8'hA5);

      frame4(8'h00, 1'b1, -1);
      idle(4);
      frame4(8'hFF, 1'b1, -1);
      idle(16);
      chk("b2b_dv_cnt", dv4_cnt, 3);
      chk("b2b_got00", got4[1], 8'h00);
      chk("b2b_gotff", got4[2], 8'hFF);
      chk("b2b_adjacent", b2b4, 0);
      chk("b2b_ferr", ferr4_cnt, 1);

      frame4(8'h55, 1'b1, 3);
      idle(8);
      chk("en_drop_dv", dv4_cnt, 3);
      chk("en_drop_byte", byte4, 8'hFF);
      chk("en_drop_active", act4, 1'b0);
      en4 = 1'b1;
      idle(8);
      frame4(8'h81, 1'b1, -1);
      idle(16);
      chk("en_81_dv", dv4_cnt, 4);
      chk("en_81_got", got4[3], 8'h81);
      chk("en_81_ferr", ferr4_cnt, 1);
      chk("adjacent_all", b2b4, 0);

      for (int k = 0; k < 256; k++) begin
         if (k == 100) begin
            b = 8'($urandom);
            frame8(b, 4);
            idle(40);
            chk("lb_rst_byte", byte8, 8'h00);
            chk("lb_rst_active", act8, 1'b0);
            chk("lb_rst_count", got8.size(), 100);
         end
         b = 8'($urandom);
         exp8.push_back(b);
         frame8(b, -1);
         idle(8);
      end
      idle(40);
      chk("lb_count", got8.size(), 256);
      chk("lb_ferr", ferr8_cnt, 0);
      n = (got8.size() < exp8.size()) ? got8.size() : exp8.size();
      for (int i = 0; i < n; i++) chk($sformatf("lb_byte%0d", i), got8[i], exp8[i]);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver: the receive end of the team's 8N1 serial link, and the counterpart of the existing transmitter.
- Synchronises the asynchronous serial line, detects the start bit, samples each bit at mid-bit, checks the stop bit, and presents the received byte with a one-cycle valid strobe.
- Sits between the board RX pin and the core; loopback against the transmitter uses the same CLKS_PER_BIT.

Parameters:
- CLKS_PER_BIT, 4, i_clk cycles per serial bit. Legal range 2..65535; counter width is $clog2(CLKS_PER_BIT)+1.
- m, 8, data bits per frame (LSB first); bit index width is $clog2(m).

Ports:
- i_clk  input  1  system clock. One clock; all logic is on the rising edge.
- i_rst_n  input  1  reset, asynchronous and active-low.
- i_enable  input  1  receiver enable. When low, no frame is accepted and any frame in progress is abandoned.
- i_Rx_serial  input  1  serial line, asynchronous to i_clk, idles high.
- o_Rx_DV  output  1  one-cycle pulse: o_Rx_byte holds a new valid byte.
- o_Rx_byte  output  m  last correctly received byte.
- o_Rx_active  output  1  high from start-bit confirmation until the end of the STOP state.
- o_frame_err  output  1  one-cycle pulse: stop bit sampled low.

Behaviour:
- Reset values (async on i_rst_n low):
  - State IDLE, all counters 0.
  - o_Rx_DV=0, o_Rx_byte=0, o_Rx_active=0, o_frame_err=0.
  - Both synchroniser flops preset to 1, so a line glitch at reset release is not treated as a start bit.
- Synchroniser: 2-flop chain on i_Rx_serial; rx_s is the second flop output. Line-to-FSM latency is 2 cycles. All decisions below use rx_s only.
- Mid-bit offset: HALF = (CLKS_PER_BIT-1)/2, integer division.
- IDLE:
  - Outputs o_Rx_DV, o_frame_err and o_Rx_active are 0; counters are cleared.
  - If i_enable=1 and rx_s=0, go to START with count=0.
- START:
  - count increments each cycle.
  - When count==HALF, sample rx_s:
    - rx_s=0: go to DATA_BITS, count=0, bit_idx=0, o_Rx_active<=1.
    - rx_s=1: false start; return to IDLE with no pulse.
- DATA_BITS:
  - count increments each cycle.
  - When count==CLKS_PER_BIT-1, sample rx_s into shift_reg[bit_idx] and set count=0.
  - If bit_idx<m-1, increment bit_idx; otherwise go to STOP.
- STOP:
  - After CLKS_PER_BIT-1 further cycles, sample rx_s.
  - rx_s=1: o_Rx_byte<=shift_reg and o_Rx_DV<=1 for exactly one cycle.
  - rx_s=0: o_frame_err<=1 for one cycle; o_Rx_byte is unchanged.
  - In both cases o_Rx_active<=0 and the FSM goes to CLEAN.
- CLEAN:
  - Clears o_Rx_DV, o_frame_err, counters and bit_idx; next state is IDLE.
  - Guarantees one idle cycle before a new start bit can be seen, so DV pulses are never back-to-back.
- Timing: with line falling edge at cycle T, the stop sample occurs at T+2+HALF+1+(m+1)*CLKS_PER_BIT-ish. The exact value is fixed by the rules above, and the bench computes it from them. o_Rx_DV is high in the cycle after the stop sample.
- i_enable low in START, DATA_BITS or STOP:
  - Next state is IDLE; o_Rx_active<=0; no DV, no error; o_Rx_byte is unchanged.
  - The rest of the frame is ignored until the line is seen low again in IDLE. Mid-frame zero bits may then false-trigger; the false-start check filters only ~HALF-cycle glitches. This is accepted behaviour.
- Break (line held low): produces one o_frame_err, then after CLEAN the FSM re-enters START immediately and repeats. This is accepted behaviour; no break detection is provided.
- Reset mid-frame: immediate return to reset values; the partial byte is discarded.
- Undefined state encoding: next state is IDLE.

Decomposition:
- Shared UART definitions header, shared with the transmitter:
  - state encodings IDLE, START, DATA_BITS, STOP, CLEAN (3 bits);
  - default CLKS_PER_BIT.
- One sub-module, uart_rx_sync: parameterised 2-flop synchroniser with reset value 1, instantiated once.

Test Plan:
- CLKS_PER_BIT=4: drive frame for 0xA5 (start 0, bits 1,0,1,0,0,1,0,1, stop 1) -> exactly one o_Rx_DV pulse, o_Rx_byte=0xA5, o_frame_err stays 0, o_Rx_active high for the frame only.
- Back-to-back 0x00 then 0xFF with a 1-bit idle gap -> two DV pulses with bytes 0x00 and 0xFF; no spurious pulse between them.
- 1-cycle low glitch on the idle line -> START is rejected at HALF, returns to IDLE, no DV, no error, o_Rx_active stays 0.
- Frame 0x3C with stop bit driven 0 -> one o_frame_err pulse, no DV, o_Rx_byte keeps its previous value 0xA5.
- i_enable dropped during data bit 3 of 0x55, then re-asserted, then a clean 0x81 frame -> 0x55 yields no DV; 0x81 is received correctly.
- Loopback: transmitter o_Tx_serial to i_Rx_serial, 256 random bytes, same CLKS_PER_BIT=8 -> every byte is matched in order; assert i_rst_n low mid-frame once, and the next frame is received correctly.
